q15_seq_divider: RTL
====================

// Module: q15_seq_divider
// PURPOSE
//  Iterative Q15 divider, the stage directly upstream of Q15ToX32: it produces the 64-bit Q15 quotient a/b that
//  Q15ToX32 turns into i32/u32. Radix-2 restoring long division on magnitudes, one operand pair in flight,
//  valid/ready on both sides. Q15 word: 64-bit two's complement, value = word / 2^48, integer part [63:48];
//  NaN/+Inf/-Inf are the q15_pkg encodings, classified by Q15Decoder.
// PARAMETERS
//  ITERS_PER_CYCLE  1   quotient bits resolved per clock; legal: 1,3,7,9,21,63 (must divide 63)
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   asynchronous, active-high reset
//  in_valid   in   1   operand pair valid
//  in_ready   out  1   divider can accept a pair (high only in IDLE)
//  a_data     in   64  Q15 dividend
//  b_data     in   64  Q15 divisor
//  out_valid  out  1   q_data valid; held until accepted
//  out_ready  in   1   consumer accepts q_data
//  q_data     out  64  Q15 quotient, feeds Q15ToX32.q15_data
// BEHAVIOUR
//  Reset (async assert, release sync to clk): state IDLE, in_ready=1, out_valid=0, q_data=0, counters/regs 0.
//  Accept when in_valid&in_ready; a/b registered that edge, in_ready drops next cycle.
//  FSM IDLE -> (accept) CLASSIFY -> special ? DONE : CALC; CALC -> (last iter) FINAL; FINAL -> DONE;
//   DONE -> (out_ready) IDLE. out_valid=1 exactly in DONE; q_data stable while out_valid & !out_ready.
//  CLASSIFY (1 cycle, Q15Decoder on a and b), precedence top-down:
//   a or b NaN -> NaN; inf/inf -> NaN; 0/0 -> NaN; inf/finite -> Inf sign sa^sb;
//   finite!=0 / 0 -> Inf sign sa; 0/nonzero or finite/inf -> 0;
//   |a| >= |b|<<15 (79-bit unsigned compare) -> overflow -> Inf sign sa^sb; else CALC.
//  CALC: dividend D=|a|<<48 (112b); remainder seeded with D[111:63] (< |b| by overflow check);
//   63 quotient bits MSB-first, ITERS_PER_CYCLE per cycle: shift in next D bit, subtract |b| if >= .
//   Iteration counter 0..63/ITERS_PER_CYCLE-1; no early termination.
//  FINAL: truncate toward zero (remainder discarded); q = (sa^sb) ? -{1'b0,Qmag} : {1'b0,Qmag};
//   a negative result of -0 is emitted as 0.
//  Latency accept -> out_valid: special = 2 cycles; normal = 63/ITERS_PER_CYCLE + 3 cycles.
//  Throughput: one pair per (latency + 1) cycles minimum (DONE->IDLE costs one cycle; no overlap).
//  in_valid ignored outside IDLE; a_data/b_data need not be held after acceptance.
//  out_ready while !out_valid has no effect. Simultaneous accept-out and new in_valid: new pair
//   accepted on the following cycle (IDLE), never in DONE.
//  rst mid-operation: in-flight result discarded, no out_valid pulse, back to IDLE.
//  All arithmetic unsigned on magnitudes; |x| of finite x fits 63 bits.
// STRUCTURE
//  q15_pkg: Q15_WIDTH=64, Q15_FRAC=48, Q15_NAN, Q15_POS_INF, Q15_NEG_INF constants,
//   state enum {IDLE,CLASSIFY,CALC,FINAL,DONE}, magnitude/negate helper functions.
//  Sub-module q15_div_step: combinational ITERS_PER_CYCLE-deep restoring step
//   (remainder, |b|, next dividend bits in -> remainder, quotient bits out).
//  Two Q15Decoder instances (a, b) for classification.
// TESTING (each also checked through a Q15ToX32 instance on q_data)
//  6.0/2.0: 0006_0000_0000_0000 / 0002_0000_0000_0000 -> 0003_0000_0000_0000, i32=3, latency 66 (ITERS=1).
//  1/3: 0001_0000_0000_0000 / 0003_0000_0000_0000 -> 0000_5555_5555_5555 (truncated); ITERS=21 -> latency 6.
//  -7/2: FFF9_0000_0000_0000 / 0002_0000_0000_0000 -> FFFC_8000_0000_0000 (-3.5); i32=FFFFFFFC.
//  Specials: 5/0 -> Q15_POS_INF; NaN/1 -> Q15_NAN; 0/0 -> Q15_NAN; 1/+Inf -> 0; each 2 cycles, no CALC.
//  Overflow: 7FFF_0000_0000_0000 / 0000_0000_0000_0001 -> Q15_POS_INF; negate a -> Q15_NEG_INF.
//  Handshake/reset: hold out_ready=0 10 cycles -> q_data stable, in_ready=0; assert rst mid-CALC ->
//   out_valid never pulses, in_ready=1 after release, next pair computes correctly.

Source files
------------

// File: rtl/q15_pkg.sv
// Shared Q15 (64-bit, 48 fractional bits) encodings, FSM states and magnitude helpers
// for the sequential divider.
package q15_pkg;

  localparam int Q15_WIDTH = 64;
  localparam int Q15_FRAC  = 48;

  // Reserved words: the most negative word is NaN, the two extremes next to it are +/-Inf.
  localparam logic [Q15_WIDTH-1:0] Q15_NAN     = 64'h8000_0000_0000_0000;
  localparam logic [Q15_WIDTH-1:0] Q15_POS_INF = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [Q15_WIDTH-1:0] Q15_NEG_INF = 64'h8000_0000_0000_0001;

  typedef enum logic [2:0] {IDLE, CLASSIFY, CALC, FINAL, DONE} div_state_t;

  typedef struct packed {
    logic        is_nan;
    logic        is_inf;
    logic        is_zero;
    logic        sign;
    logic [62:0] mag;
  } q15_class_t;

  // |x| for a finite word always fits in 63 bits, so only the low bits are negated.
  function automatic logic [62:0] q15_mag(input logic [63:0] x);
    return x[63] ? (~x[62:0] + 63'd1) : x[62:0];
  endfunction

  function automatic logic [63:0] q15_negate(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

  function automatic q15_class_t q15_decode(input logic [63:0] x);
    q15_class_t c;
    c.is_nan  = (x == Q15_NAN);
    c.is_inf  = (x == Q15_POS_INF) || (x == Q15_NEG_INF);
    c.is_zero = (x == 64'd0);
    c.sign    = x[63];
    c.mag     = q15_mag(x);
    return c;
  endfunction

endpackage

// File: rtl/q15_div_step.sv
// Combinational restoring-division slice: resolves ITERS quotient bits, MSB first.
module q15_div_step #(
  parameter int ITERS = 1
) (
  input  logic [62:0]      rem_in,
  input  logic [62:0]      divisor,
  input  logic [ITERS-1:0] bits_in,
  output logic [62:0]      rem_out,
  output logic [ITERS-1:0] q_bits
);

  always_comb begin
    logic [63:0] trial;
    logic [62:0] r;
    r      = rem_in;
    trial  = '0;
    q_bits = '0;
    // r < divisor on entry, so the shifted trial fits 64 bits and the result fits 63 again.
    for (int i = ITERS - 1; i >= 0; i--) begin
      trial = {r, bits_in[i]};
      if (trial >= {1'b0, divisor}) begin
        trial     = trial - {1'b0, divisor};
        q_bits[i] = 1'b1;
      end
      r = trial[62:0];
    end
    rem_out = r;
  end

endmodule

// File: rtl/q15_seq_divider.sv
// Iterative Q15 divider a/b: classify specials, then radix-2 restoring division on
// magnitudes, ITERS_PER_CYCLE quotient bits per clock, valid/ready on both sides.
module q15_seq_divider
  import q15_pkg::*;
#(
  parameter int ITERS_PER_CYCLE = 1  // must divide 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a_data,
  input  logic [63:0] b_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] q_data,
  output div_state_t  dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready; in_ready is high
  // only in IDLE, out_valid only in DONE, and q_data is held until out_ready is seen.

  localparam int         N_STEPS   = 63 / ITERS_PER_CYCLE;
  localparam logic [5:0] LAST_STEP = 6'(N_STEPS - 1);

  div_state_t state, state_d;
  logic [63:0] a_reg, b_reg, q_reg;
  logic [62:0] divisor, rem, dbits, qmag, rem_next;
  logic [ITERS_PER_CYCLE-1:0] step_q;
  logic [5:0]  cnt;
  logic        neg_q;

  q15_class_t ca, cb;
  logic        special, overflow, sx;
  logic [63:0] special_val;

  assign ca       = q15_decode(a_reg);
  assign cb       = q15_decode(b_reg);
  assign sx       = ca.sign ^ cb.sign;
  // Quotient fits 63 bits only if |a| < |b| * 2^15.
  assign overflow = {16'b0, ca.mag} >= {1'b0, cb.mag, 15'b0};

  always_comb begin
    special     = 1'b1;
    special_val = '0;
    if (ca.is_nan || cb.is_nan)         special_val = Q15_NAN;
    else if (ca.is_inf && cb.is_inf)    special_val = Q15_NAN;
    else if (ca.is_zero && cb.is_zero)  special_val = Q15_NAN;
    else if (ca.is_inf)                 special_val = sx ? Q15_NEG_INF : Q15_POS_INF;
    else if (cb.is_zero)                special_val = ca.sign ? Q15_NEG_INF : Q15_POS_INF;
    else if (ca.is_zero || cb.is_inf)   special_val = '0;
    else if (overflow)                  special_val = sx ? Q15_NEG_INF : Q15_POS_INF;
    else                                special     = 1'b0;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (in_valid) state_d = CLASSIFY;
      CLASSIFY: state_d = special ? DONE : CALC;
      CALC:     if (cnt == LAST_STEP) state_d = FINAL;
      FINAL:    state_d = DONE;
      DONE:     if (out_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  q15_div_step #(.ITERS(ITERS_PER_CYCLE)) u_step (
    .rem_in  (rem),
    .divisor (divisor),
    .bits_in (dbits[62 -: ITERS_PER_CYCLE]),
    .rem_out (rem_next),
    .q_bits  (step_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      q_reg   <= '0;
      divisor <= '0;
      rem     <= '0;
      dbits   <= '0;
      qmag    <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg <= a_data;
          b_reg <= b_data;
        end
        CLASSIFY: begin
          // Dividend is |a| << 48; its top 49 bits seed the remainder, the low 63 stream in.
          neg_q   <= sx;
          divisor <= cb.mag;
          rem     <= {15'b0, ca.mag[62:15]};
          dbits   <= {ca.mag[14:0], 48'b0};
          qmag    <= '0;
          cnt     <= '0;
          if (special) q_reg <= special_val;
        end
        CALC: begin
          rem   <= rem_next;
          dbits <= dbits << ITERS_PER_CYCLE;
          qmag  <= (qmag << ITERS_PER_CYCLE) | 63'(step_q);
          cnt   <= cnt + 6'd1;
        end
        FINAL: q_reg <= neg_q ? q15_negate({1'b0, qmag}) : {1'b0, qmag};
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign q_data    = q_reg;
  assign dbg_state = state;

endmodule
